// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: shared iterative RV M multiply/divide engine retiring DBITS bits per cycle.
// Optional MULDIV_FAST_MUL_EN: multiplies use a combinational full-width product instead of iterating.
module muldiv_iter_unit #(
    parameter int XLEN  = 32,
    parameter int DBITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            clear,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    output logic            busy,
    output logic            ready,
    output logic [XLEN-1:0] result
);
    localparam int N  = XLEN / DBITS;
    localparam int CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] acc_hi, acc_lo, opnd_b;
    logic            neg_res;
    logic [CW-1:0]   count;

    logic            is_div, a_signed, b_signed, sa, sb;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] abs_a, abs_b, special_res;

    // Operand decode works on the latched operands during PREP.
    assign is_div   = op_q[2];
    assign a_signed = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
    assign b_signed = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
    assign sa       = a_signed & a_q[XLEN-1];
    assign sb       = b_signed & b_q[XLEN-1];
    assign abs_a    = sa ? -a_q : a_q;
    assign abs_b    = sb ? -b_q : b_q;
    assign div_zero = is_div && (b_q == '0);
    assign div_ovf  = is_div && !op_q[0] && (a_q == MOST_NEG) && (b_q == '1);
    assign special  = div_zero || div_ovf;
    assign special_res = div_zero ? (op_q[1] ? a_q : '1)
                                  : (op_q[1] ? '0 : MOST_NEG);

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
    logic signed [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    assign fast_a    = {{XLEN{a_signed & a_q[XLEN-1]}}, a_q};
    assign fast_b    = {{XLEN{b_signed & b_q[XLEN-1]}}, b_q};
    assign fast_prod = fast_a * fast_b;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    logic [XLEN+DBITS-1:0] pp, msum;
    logic [XLEN:0]         trial;
    logic [XLEN-1:0]       rem_w, quo_w;

    // One cycle of work: DBITS shift-add multiply steps, or DBITS restoring divide steps.
    always_comb begin
        pp = '0;
        for (int j = 0; j < DBITS; j++)
            if (acc_lo[j]) pp = pp + ({{DBITS{1'b0}}, opnd_b} << j);
        msum  = {{DBITS{1'b0}}, acc_hi} + pp;
        rem_w = acc_hi;
        quo_w = acc_lo;
        trial = '0;
        for (int i = 0; i < DBITS; i++) begin
            trial = {rem_w, quo_w[XLEN-1]};
            if (trial >= {1'b0, opnd_b}) begin
                trial = trial - {1'b0, opnd_b};
                quo_w = {quo_w[XLEN-2:0], 1'b1};
            end else begin
                quo_w = {quo_w[XLEN-2:0], 1'b0};
            end
            rem_w = trial[XLEN-1:0];
        end
    end

    logic [2*XLEN-1:0] full;
    logic [XLEN-1:0]   qr, fix_res;

    always_comb begin
        full = {acc_hi, acc_lo};
        if (neg_res) full = -full;
        qr = op_q[1] ? acc_hi : acc_lo;
        if (neg_res) qr = -qr;
        if (is_div)
            fix_res = qr;
        else if (op_q == 3'd0)
            fix_res = full[XLEN-1:0];
        else
            fix_res = full[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable) state_nxt = PREP;
            PREP: begin
                if (special)                 state_nxt = DONE;
                else if (FAST_MUL && !is_div) state_nxt = FIX;
                else                         state_nxt = ITER;
            end
            ITER: if (count == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    // A flush freezes every register, so result keeps its last delivered value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd_b  <= '0;
            neg_res <= 1'b0;
            count   <= '0;
            result  <= '0;
        end else if (!clear) begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        op_q <= op;
                        a_q  <= rdata1;
                        b_q  <= rdata2;
                    end
                end
                PREP: begin
                    acc_hi  <= '0;
                    acc_lo  <= abs_a;
                    opnd_b  <= abs_b;
                    neg_res <= (is_div && op_q[1]) ? sa : (sa ^ sb);
                    count   <= CW'(N);
                    if (special) result <= special_res;
`ifdef MULDIV_FAST_MUL_EN
                    if (!is_div) begin
                        {acc_hi, acc_lo} <= fast_prod;
                        neg_res          <= 1'b0;
                    end
`endif
                end
                ITER: begin
                    count <= count - CW'(1);
                    if (is_div) begin
                        acc_hi <= rem_w;
                        acc_lo <= quo_w;
                    end else begin
                        acc_hi <= msum[XLEN+DBITS-1:DBITS];
                        acc_lo <= {msum[DBITS-1:0], acc_lo[XLEN-1:DBITS]};
                    end
                end
                FIX: result <= fix_res;
                default: ;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign ready = (state == DONE);

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Scoreboard bench for muldiv_iter_unit: a DBITS=1 and a DBITS=4 instance, directed vectors.
module tb_muldiv_iter_unit;
    logic        clk;
    logic        rst;
    logic        en     [2];
    logic        clr    [2];
    logic [2:0]  opv    [2];
    logic [31:0] r1     [2];
    logic [31:0] r2     [2];
    logic        busy_w [2];
    logic        ready_w[2];
    logic [31:0] result_w[2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] value;
        int          lat;
        int          issue;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL_A = 3;
    localparam int LAT_MUL_B = 3;
`else
    localparam int LAT_MUL_A = 35;
    localparam int LAT_MUL_B = 11;
`endif

    muldiv_iter_unit #(.XLEN(32), .DBITS(1)) dut_a (
        .clk(clk), .rst(rst), .enable(en[0]), .clear(clr[0]), .op(opv[0]),
        .rdata1(r1[0]), .rdata2(r2[0]), .busy(busy_w[0]), .ready(ready_w[0]),
        .result(result_w[0])
    );

    muldiv_iter_unit #(.XLEN(32), .DBITS(4)) dut_b (
        .clk(clk), .rst(rst), .enable(en[1]), .clear(clr[1]), .op(opv[1]),
        .rdata1(r1[1]), .rdata2(r2[1]), .busy(busy_w[1]), .ready(ready_w[1]),
        .result(result_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp, input int lat,
                                 input bit pulse);
        exp_t e;
        int   n;
        @(negedge clk);
        opv[d] = o;
        r1[d]  = a;
        r2[d]  = b;
        en[d]  = 1'b1;
        e.value = exp;
        e.lat   = lat;
        e.issue = cyc;
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        @(negedge clk);
        en[d] = 1'b0;
        if (pulse) begin
            repeat (3) @(negedge clk);
            opv[d] = 3'd0;
            r1[d]  = 32'd9;
            r2[d]  = 32'd9;
            en[d]  = 1'b1;
            @(negedge clk);
            en[d] = 1'b0;
        end
        n = 0;
        while (busy_w[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy_w[d]) begin
            checks++;
            failures++;
            $display("[TB] FAIL dut%0d_timeout actual=busy expected=idle", d);
        end
    endtask

    // Monitors: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ready_w[0]) begin
            if (sb0.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL dut0_unexpected_ready actual=1 expected=0");
            end else begin
                e = sb0.pop_front();
                checkOutput("dut0_result", result_w[0], e.value);
                checkOutput("dut0_latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ready_w[1]) begin
            if (sb1.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL dut1_unexpected_ready actual=1 expected=0");
            end else begin
                e = sb1.pop_front();
                checkOutput("dut1_result", result_w[1], e.value);
                checkOutput("dut1_latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en[i]  = 1'b0;
            clr[i] = 1'b0;
            opv[i] = 3'd0;
            r1[i]  = 32'd0;
            r2[i]  = 32'd0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_busy", 32'(busy_w[i]), 32'd0);
            checkOutput("reset_ready", 32'(ready_w[i]), 32'd0);
            checkOutput("reset_result", result_w[i], 32'd0);
        end

        // DBITS=1 instance
        applyStimulus(0, 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35, 1'b0);

        // Reset in the middle of an operation aborts it without a ready pulse.
        @(negedge clk);
        opv[0] = 3'd4;
        r1[0]  = 32'hFFFFFFF9;
        r2[0]  = 32'd2;
        en[0]  = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("busy_before_reset", 32'(busy_w[0]), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("midop_reset_busy", 32'(busy_w[0]), 32'd0);
        checkOutput("midop_reset_result", result_w[0], 32'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(0, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 35, 1'b0);
        applyStimulus(0, 3'd5, 32'h00001234, 32'd0, 32'hFFFFFFFF, 2, 1'b0);
        applyStimulus(0, 3'd7, 32'h00001234, 32'd0, 32'h00001234, 2, 1'b0);
        applyStimulus(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 1'b0);
        applyStimulus(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2, 1'b0);
        applyStimulus(0, 3'd4, 32'd0, 32'd0, 32'hFFFFFFFF, 2, 1'b0);
        applyStimulus(0, 3'd4, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 35, 1'b0);
        applyStimulus(0, 3'd6, 32'd100, 32'hFFFFFFF9, 32'd2, 35, 1'b0);
        applyStimulus(0, 3'd7, 32'd100, 32'd7, 32'd2, 35, 1'b0);
        applyStimulus(0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, LAT_MUL_A, 1'b0);
        applyStimulus(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_MUL_A, 1'b0);
        applyStimulus(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MUL_A, 1'b0);
        applyStimulus(0, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, LAT_MUL_A, 1'b0);
        applyStimulus(0, 3'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, LAT_MUL_A, 1'b0);
        applyStimulus(0, 3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, LAT_MUL_A, 1'b0);

        // Flush during ITER cycle 10 of a divu.
        @(negedge clk);
        opv[0] = 3'd5;
        r1[0]  = 32'd1000;
        r2[0]  = 32'd3;
        en[0]  = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("busy_before_clear", 32'(busy_w[0]), 32'd1);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        checkOutput("clear_busy", 32'(busy_w[0]), 32'd0);
        checkOutput("clear_ready", 32'(ready_w[0]), 32'd0);
        checkOutput("clear_result_held", result_w[0], 32'hFFFFFFF1);
        applyStimulus(0, 3'd5, 32'd1000, 32'd3, 32'd333, 35, 1'b0);

        // DBITS=4 instance
        applyStimulus(1, 3'd0, 32'd7, 32'd6, 32'd42, LAT_MUL_B, 1'b0);
        applyStimulus(1, 3'd5, 32'd100, 32'd7, 32'd14, 11, 1'b1);
        applyStimulus(1, 3'd4, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 11, 1'b0);
        applyStimulus(1, 3'd6, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 11, 1'b0);
        applyStimulus(1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MUL_B, 1'b0);
        applyStimulus(1, 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 2, 1'b0);

        repeat (5) @(negedge clk);
        checkOutput("sb0_drained", 32'(sb0.size()), 32'd0);
        checkOutput("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
